vector_writeback_unit: RTL and testbench

Downstream of the vector function unit. Captures the packed ALU result when the function unit reports `VEC_ALU_FINISHED`. Merges the result with the old destination register under the mask, length and element-width rules. Writes the merged vector into the vector register file as a sequence of half-width beats, using a ready handshake.

---
 rtl/vector_writeback_unit_pkg.sv | 38 +++
 rtl/vector_writeback_unit_if.sv | 57 +++++
 rtl/vector_writeback_unit_mask_merge.sv | 50 +++++
 rtl/vector_writeback_unit.sv | 156 +++++++++++++++
 tb/tb_vector_writeback_unit.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vector_writeback_unit_pkg.sv
// ---------------------------------------------------------------------------
// vector_writeback_unit_pkg
// Shared encodings for the vector writeback path:
//   VEC_ALU_*  : function-unit status codes seen on alu_status
//   *_BYTE     : VSEW element-width codes
//   wb_state_t : writeback FSM states (WB_IDLE/WB_MERGE/WB_WRITE/WB_DONE)
//   sewShift() : log2 of the element width in bits for a VSEW code
// ---------------------------------------------------------------------------
package vector_writeback_unit_pkg;

    localparam logic [1:0] VEC_ALU_IDLE     = 2'b00;
    localparam logic [1:0] VEC_ALU_BUSY     = 2'b01;
    localparam logic [1:0] VEC_ALU_FINISHED = 2'b10;

    localparam logic [2:0] ONE_BYTE   = 3'b000;
    localparam logic [2:0] TWO_BYTE   = 3'b001;
    localparam logic [2:0] FOUR_BYTE  = 3'b010;
    localparam logic [2:0] EIGHT_BYTE = 3'b011;

    typedef enum logic [1:0] {
        WB_IDLE  = 2'd0,
        WB_MERGE = 2'd1,
        WB_WRITE = 2'd2,
        WB_DONE  = 2'd3
    } wb_state_t;

    // Element width in bits is 1 << sewShift(vsew); unknown codes fall back to bytes
    function automatic int sewShift(input logic [2:0] vsew);
        case (vsew)
            ONE_BYTE:   sewShift = 3;
            TWO_BYTE:   sewShift = 4;
            FOUR_BYTE:  sewShift = 5;
            EIGHT_BYTE: sewShift = 6;
            default:    sewShift = 3;
        endcase
    endfunction

endpackage

// File: rtl/vector_writeback_unit_if.sv
// ---------------------------------------------------------------------------
// vector_writeback_unit_if
// Bundles everything between the vector function unit / control side and the
// writeback unit, plus the register-file write port the unit drives.
//   master : upstream side (control, function unit, register file)
//   slave  : the writeback unit itself
// Signals: rdy_in, alu_status, alu_is_mask, alu_result, wb_enable, vd_index,
//   VSEW, vm, mask, length, old_vd, vreg_wr_ready (to unit);
//   vreg_wr_en, vreg_wr_index, vreg_wr_beat, vreg_wr_data, wb_busy, wb_done,
//   wb_overrun (from unit).
// ---------------------------------------------------------------------------
interface vector_writeback_unit_if #(
    parameter int DATA_LEN        = 32,
    parameter int VECTOR_SIZE     = 8,
    parameter int VREG_INDEX_SIZE = 5,
    parameter int BEAT_NUM        = 2
);
    localparam int VLEN   = VECTOR_SIZE * DATA_LEN;
    localparam int BW     = VLEN / BEAT_NUM;
    localparam int BEAT_W = (BEAT_NUM > 1) ? $clog2(BEAT_NUM) : 1;

    logic                       rdy_in;
    logic [1:0]                 alu_status;
    logic                       alu_is_mask;
    logic [VLEN-1:0]            alu_result;
    logic                       wb_enable;
    logic [VREG_INDEX_SIZE-1:0] vd_index;
    logic [2:0]                 VSEW;
    logic                       vm;
    logic [VLEN-1:0]            mask;
    logic [DATA_LEN-1:0]        length;
    logic [VLEN-1:0]            old_vd;
    logic                       vreg_wr_ready;

    logic                       vreg_wr_en;
    logic [VREG_INDEX_SIZE-1:0] vreg_wr_index;
    logic [BEAT_W-1:0]          vreg_wr_beat;
    logic [BW-1:0]              vreg_wr_data;
    logic                       wb_busy;
    logic                       wb_done;
    logic                       wb_overrun;

    modport master (
        output rdy_in, alu_status, alu_is_mask, alu_result, wb_enable, vd_index,
               VSEW, vm, mask, length, old_vd, vreg_wr_ready,
        input  vreg_wr_en, vreg_wr_index, vreg_wr_beat, vreg_wr_data,
               wb_busy, wb_done, wb_overrun
    );

    modport slave (
        input  rdy_in, alu_status, alu_is_mask, alu_result, wb_enable, vd_index,
               VSEW, vm, mask, length, old_vd, vreg_wr_ready,
        output vreg_wr_en, vreg_wr_index, vreg_wr_beat, vreg_wr_data,
               wb_busy, wb_done, wb_overrun
    );

endinterface

// File: rtl/vector_writeback_unit_mask_merge.sv
// ---------------------------------------------------------------------------
// vector_mask_merge
// Purely combinational merge of a new vector result into the old destination.
//   i_old    : current destination register contents
//   i_new    : packed function-unit result
//   i_mask   : v0 contents, bit i governs element i
//   i_vm     : 1 = unmasked operation
//   i_effLen : vl already clamped to VLMAX
//   i_vsew   : destination element width code
//   i_isMask : result is one bit per element
//   o_merged : merged vector
// ---------------------------------------------------------------------------
module vector_mask_merge
    import vector_writeback_unit_pkg::*;
#(
    parameter int VLEN     = 256,
    parameter int DATA_LEN = 32
) (
    input  logic [VLEN-1:0]     i_old,
    input  logic [VLEN-1:0]     i_new,
    input  logic [VLEN-1:0]     i_mask,
    input  logic                i_vm,
    input  logic [DATA_LEN-1:0] i_effLen,
    input  logic [2:0]          i_vsew,
    input  logic                i_isMask,
    output logic [VLEN-1:0]     o_merged
);
    localparam int IDX_W = $clog2(VLEN);

    int               w_shift;
    logic [IDX_W-1:0] w_elemIdx;
    logic             w_active;

    // Walk every bit of the register and work out which element it belongs to.
    // For a mask result each bit is its own element; otherwise the element
    // index is the bit position divided by the element width. Inactive bits
    // (masked-off or past the effective length) keep the old value.
    always_comb begin
        o_merged  = i_old;
        w_shift   = sewShift(i_vsew);
        w_elemIdx = '0;
        w_active  = 1'b0;
        for (int j = 0; j < VLEN; j++) begin
            w_elemIdx   = IDX_W'(i_isMask ? j : (j >> w_shift));
            w_active    = (DATA_LEN'(w_elemIdx) < i_effLen) && (i_vm || i_mask[w_elemIdx]);
            o_merged[j] = w_active ? i_new[j] : i_old[j];
        end
    end

endmodule

// File: rtl/vector_writeback_unit.sv
// ---------------------------------------------------------------------------
// vector_writeback_unit
// Captures a finished vector result, merges it with the old destination under
// mask / length / element-width rules and writes it to the register file as
// BEAT_NUM half-register beats over a ready handshake.
//   clk, rst : clock and synchronous active-high reset
//   bus      : vector_writeback_unit_if.slave (function-unit inputs, write
//              port outputs, busy/done/overrun status)
// ---------------------------------------------------------------------------
module vector_writeback_unit
    import vector_writeback_unit_pkg::*;
#(
    parameter int DATA_LEN        = 32,
    parameter int VECTOR_SIZE     = 8,
    parameter int VREG_INDEX_SIZE = 5,
    parameter int BEAT_NUM        = 2
) (
    input logic                    clk,
    input logic                    rst,
    vector_writeback_unit_if.slave bus
);
    localparam int VLEN   = VECTOR_SIZE * DATA_LEN;
    localparam int BW     = VLEN / BEAT_NUM;
    localparam int BEAT_W = (BEAT_NUM > 1) ? $clog2(BEAT_NUM) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEAT_NUM - 1);

    wb_state_t                  r_state;
    logic [VLEN-1:0]            r_result;
    logic [VLEN-1:0]            r_mask;
    logic [VLEN-1:0]            r_oldVd;
    logic [VLEN-1:0]            r_merged;
    logic                       r_isMask;
    logic                       r_vm;
    logic [VREG_INDEX_SIZE-1:0] r_vdIndex;
    logic [2:0]                 r_vsew;
    logic [DATA_LEN-1:0]        r_length;
    logic                       r_wrEn;
    logic [VREG_INDEX_SIZE-1:0] r_wrIndex;
    logic [BEAT_W-1:0]          r_beat;
    logic [BW-1:0]              r_wrData;
    logic                       r_done;
    logic                       r_overrun;

    logic                       w_finished;
    logic [DATA_LEN-1:0]        w_vlmax;
    logic [DATA_LEN-1:0]        w_effLen;
    logic [VLEN-1:0]            w_merged;
    logic [BEAT_W-1:0]          w_nextBeat;
    logic [BW-1:0]              w_beats [BEAT_NUM];

    assign w_finished = (bus.alu_status == VEC_ALU_FINISHED);

    // vl may exceed what the register can hold at this element width, so
    // clamp it to VLMAX before it reaches the merge.
    assign w_vlmax    = DATA_LEN'(VLEN >> sewShift(r_vsew));
    assign w_effLen   = (r_length > w_vlmax) ? w_vlmax : r_length;
    assign w_nextBeat = r_beat + BEAT_W'(1);

    vector_mask_merge #(
        .VLEN     (VLEN),
        .DATA_LEN (DATA_LEN)
    ) u_merge (
        .i_old    (r_oldVd),
        .i_new    (r_result),
        .i_mask   (r_mask),
        .i_vm     (r_vm),
        .i_effLen (w_effLen),
        .i_vsew   (r_vsew),
        .i_isMask (r_isMask),
        .o_merged (w_merged)
    );

    // Slice the registered merged vector into beats so the next beat can be
    // picked by index when the current one is accepted.
    for (genvar b = 0; b < BEAT_NUM; b++) begin : g_beat
        assign w_beats[b] = r_merged[b*BW +: BW];
    end

    assign bus.wb_busy       = (r_state != WB_IDLE);
    assign bus.vreg_wr_en    = r_wrEn;
    assign bus.vreg_wr_index = r_wrIndex;
    assign bus.vreg_wr_beat  = r_beat;
    assign bus.vreg_wr_data  = r_wrData;
    assign bus.wb_done       = r_done;
    assign bus.wb_overrun    = r_overrun;

    // Writeback FSM. Everything is frozen while rdy_in is low. A FINISHED
    // that shows up outside IDLE is dropped and only leaves the sticky
    // overrun flag behind. Beat 0 is loaded straight from the merge output
    // on the MERGE edge so it appears the cycle right after MERGE; later
    // beats come from the registered copy and only advance on ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= WB_IDLE;
            r_wrEn    <= 1'b0;
            r_wrIndex <= '0;
            r_beat    <= '0;
            r_wrData  <= '0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else if (bus.rdy_in) begin
            r_done <= 1'b0;
            if (w_finished && (r_state != WB_IDLE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                WB_IDLE: begin
                    if (w_finished) begin
                        if (bus.wb_enable && (bus.length != '0)) begin
                            r_result  <= bus.alu_result;
                            r_isMask  <= bus.alu_is_mask;
                            r_vdIndex <= bus.vd_index;
                            r_vsew    <= bus.VSEW;
                            r_vm      <= bus.vm;
                            r_mask    <= bus.mask;
                            r_oldVd   <= bus.old_vd;
                            r_length  <= bus.length;
                            r_state   <= WB_MERGE;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= WB_DONE;
                        end
                    end
                end
                WB_MERGE: begin
                    r_merged  <= w_merged;
                    r_wrEn    <= 1'b1;
                    r_wrIndex <= r_vdIndex;
                    r_beat    <= '0;
                    r_wrData  <= w_merged[BW-1:0];
                    r_state   <= WB_WRITE;
                end
                WB_WRITE: begin
                    if (bus.vreg_wr_ready) begin
                        if (r_beat == LAST_BEAT) begin
                            r_wrEn  <= 1'b0;
                            r_beat  <= '0;
                            r_done  <= 1'b1;
                            r_state <= WB_DONE;
                        end else begin
                            r_beat   <= w_nextBeat;
                            r_wrData <= w_beats[w_nextBeat];
                        end
                    end
                end
                WB_DONE: begin
                    r_state <= WB_IDLE;
                end
                default: begin
                    r_state <= WB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vector_writeback_unit.sv
// ---------------------------------------------------------------------------
// tb_vector_writeback_unit
// Self-checking bench for vector_writeback_unit. A reference merge model
// fills a scoreboard with the expected beats whenever a writeback is issued;
// each scenario task pops the scoreboard as beats are accepted.
// ---------------------------------------------------------------------------
module tb_vector_writeback_unit;
    import vector_writeback_unit_pkg::*;

    localparam int DATA_LEN        = 32;
    localparam int VECTOR_SIZE     = 8;
    localparam int VREG_INDEX_SIZE = 5;
    localparam int BEAT_NUM        = 2;
    localparam int VLEN            = VECTOR_SIZE * DATA_LEN;
    localparam int BW              = VLEN / BEAT_NUM;
    localparam int BEAT_W          = 1;

    typedef struct {
        logic [VREG_INDEX_SIZE-1:0] idx;
        logic [BEAT_W-1:0]          beat;
        logic [BW-1:0]              data;
    } exp_t;

    typedef struct {
        logic [VREG_INDEX_SIZE-1:0] idx;
        logic [BEAT_W-1:0]          beat;
        logic [BW-1:0]              data;
        bit                         acc;
        int                         cyc;
    } obs_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    exp_t sb[$];
    obs_t obs[$];

    vector_writeback_unit_if #(
        .DATA_LEN(DATA_LEN), .VECTOR_SIZE(VECTOR_SIZE),
        .VREG_INDEX_SIZE(VREG_INDEX_SIZE), .BEAT_NUM(BEAT_NUM)
    ) bus ();

    vector_writeback_unit #(
        .DATA_LEN(DATA_LEN), .VECTOR_SIZE(VECTOR_SIZE),
        .VREG_INDEX_SIZE(VREG_INDEX_SIZE), .BEAT_NUM(BEAT_NUM)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference merge written element-by-element from the merge rules
    function automatic logic [VLEN-1:0] modelMerge(
        input logic [VLEN-1:0] oldV, input logic [VLEN-1:0] newV,
        input logic [VLEN-1:0] maskV, input bit vm, input int len,
        input int sew, input bit isMask);
        int sewBits;
        int vlmax;
        int eff;
        logic [VLEN-1:0] r;
        sewBits = 8 << sew;
        vlmax   = VLEN / sewBits;
        eff     = (len < vlmax) ? len : vlmax;
        r       = oldV;
        if (isMask) begin
            for (int i = 0; i < eff; i++)
                if (vm || maskV[i]) r[i] = newV[i];
        end else begin
            for (int e = 0; e < eff; e++)
                if (vm || maskV[e])
                    for (int b = 0; b < sewBits; b++)
                        r[e*sewBits + b] = newV[e*sewBits + b];
        end
        return r;
    endfunction

    // Drives one FINISHED cycle (edge N) and optionally queues expected beats.
    // Returns in cycle N+1, just after edge N.
    task automatic applyStimulus(
        input logic [VLEN-1:0] res, input logic [VLEN-1:0] oldV,
        input logic [VLEN-1:0] maskV, input bit isMask, input bit wbEn,
        input bit vm, input logic [2:0] sew, input int len,
        input logic [VREG_INDEX_SIZE-1:0] vd, input bit push);
        logic [VLEN-1:0] m;
        exp_t e;
        bus.alu_status  = VEC_ALU_FINISHED;
        bus.alu_result  = res;
        bus.old_vd      = oldV;
        bus.mask        = maskV;
        bus.alu_is_mask = isMask;
        bus.wb_enable   = wbEn;
        bus.vm          = vm;
        bus.VSEW        = sew;
        bus.length      = DATA_LEN'(len);
        bus.vd_index    = vd;
        if (push) begin
            m = modelMerge(oldV, res, maskV, vm, len, int'(sew), isMask);
            for (int b = 0; b < BEAT_NUM; b++) begin
                e.idx  = vd;
                e.beat = BEAT_W'(b);
                e.data = m[b*BW +: BW];
                sb.push_back(e);
            end
        end
        @(posedge clk); #1;
        bus.alu_status = VEC_ALU_IDLE;
    endtask

    // Runs cycles from N+1 until wb_done is seen (bounded), driving ready,
    // rdy_in and an optional stray FINISHED; records every driven beat.
    task automatic collectBeats(input int lowBeat, input int lowCycles,
                                input int finishCyc, input int freezeCyc,
                                input int freezeLen, output int doneCyc);
        int lowCnt;
        obs_t o;
        obs.delete();
        doneCyc = -1;
        lowCnt  = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            bus.rdy_in = !(cyc >= freezeCyc && cyc < freezeCyc + freezeLen);
            if (cyc == finishCyc) begin
                bus.alu_status = VEC_ALU_FINISHED;
                bus.alu_result = ~bus.alu_result;
                bus.old_vd     = ~bus.old_vd;
                bus.wb_enable  = 1'b1;
                bus.length     = 32'd8;
            end else begin
                bus.alu_status = VEC_ALU_IDLE;
            end
            if (bus.vreg_wr_en && int'(bus.vreg_wr_beat) == lowBeat && lowCnt < lowCycles) begin
                bus.vreg_wr_ready = 1'b0;
                lowCnt++;
            end else begin
                bus.vreg_wr_ready = 1'b1;
            end
            if (bus.vreg_wr_en) begin
                o.idx  = bus.vreg_wr_index;
                o.beat = bus.vreg_wr_beat;
                o.data = bus.vreg_wr_data;
                o.acc  = bus.vreg_wr_ready && bus.rdy_in;
                o.cyc  = cyc;
                obs.push_back(o);
            end
            if (bus.wb_done && doneCyc < 0) doneCyc = cyc;
            @(posedge clk); #1;
            if (doneCyc >= 0) break;
        end
        bus.alu_status = VEC_ALU_IDLE;
        bus.rdy_in     = 1'b1;
    endtask

    task automatic test_reset();
        rst               = 1'b1;
        bus.rdy_in        = 1'b1;
        bus.alu_status    = VEC_ALU_IDLE;
        bus.alu_is_mask   = 1'b0;
        bus.alu_result    = '0;
        bus.wb_enable     = 1'b0;
        bus.vd_index      = '0;
        bus.VSEW          = FOUR_BYTE;
        bus.vm            = 1'b1;
        bus.mask          = '0;
        bus.length        = '0;
        bus.old_vd        = '0;
        bus.vreg_wr_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.wb_busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%0b exp=0", bus.wb_busy); end
        checks++;
        if (bus.vreg_wr_en !== 1'b0) begin failures++; $display("[TB] FAIL reset_wr_en got=%0b exp=0", bus.vreg_wr_en); end
        checks++;
        if (bus.wb_done !== 1'b0 || bus.wb_overrun !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_done_overrun got=%0b%0b exp=00", bus.wb_done, bus.wb_overrun);
        end
        checks++;
        if (bus.vreg_wr_data !== '0 || bus.vreg_wr_index !== '0 || bus.vreg_wr_beat !== '0) begin
            failures++; $display("[TB] FAIL reset_wr_bus got=%h/%0d/%0d exp=0", bus.vreg_wr_data, bus.vreg_wr_index, bus.vreg_wr_beat);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // Several merge patterns, all with ready held high
    task automatic test_merge_patterns();
        logic [VLEN-1:0] res [5];
        logic [VLEN-1:0] oldv [5];
        logic [VLEN-1:0] msk [5];
        bit              isM [5];
        bit              vmv [5];
        logic [2:0]      sew [5];
        int              len [5];
        int              doneCyc;
        int              nAcc;
        int              firstCyc;
        exp_t            e;
        res[0] = {8{32'h1111_1111}}; oldv[0] = {8{32'h5555_5555}}; msk[0] = '0;
        isM[0] = 0; vmv[0] = 1; sew[0] = FOUR_BYTE; len[0] = 8;
        res[1] = {32'h1000_0007, 32'h1000_0006, 32'h1000_0005, 32'h1000_0004,
                  32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000};
        oldv[1] = {8{32'hAAAA_AAAA}}; msk[1] = VLEN'(8'hD5);
        isM[1] = 0; vmv[1] = 0; sew[1] = FOUR_BYTE; len[1] = 5;
        res[2] = VLEN'(32'hFFFF_F3FF); oldv[2] = '1; msk[2] = '0;
        isM[2] = 1; vmv[2] = 1; sew[2] = ONE_BYTE; len[2] = 10;
        res[3] = VLEN'(32'h0000_00A5); oldv[3] = '1; msk[3] = '0;
        isM[3] = 1; vmv[3] = 1; sew[3] = FOUR_BYTE; len[3] = 20;
        res[4] = {8{32'h0123_4567}}; oldv[4] = {8{32'hFEDC_BA98}}; msk[4] = VLEN'(32'h0000_5A3C);
        isM[4] = 0; vmv[4] = 0; sew[4] = TWO_BYTE; len[4] = 11;
        for (int t = 0; t < 5; t++) begin
            applyStimulus(res[t], oldv[t], msk[t], isM[t], 1'b1, vmv[t], sew[t], len[t],
                          VREG_INDEX_SIZE'(t + 3), 1'b1);
            collectBeats(-1, 0, 0, 0, 0, doneCyc);
            firstCyc = (obs.size() > 0) ? obs[0].cyc : -1;
            checks++;
            if (firstCyc !== 2) begin failures++; $display("[TB] FAIL merge%0d_first_beat_cycle got=%0d exp=2", t, firstCyc); end
            nAcc = 0;
            foreach (obs[k]) begin
                if (obs[k].acc) begin
                    nAcc++;
                    checks++;
                    if (sb.size() == 0) begin
                        failures++; $display("[TB] FAIL merge%0d_extra_beat got=%h exp=none", t, obs[k].data);
                    end else begin
                        e = sb.pop_front();
                        if (obs[k].data !== e.data || obs[k].idx !== e.idx || obs[k].beat !== e.beat) begin
                            failures++;
                            $display("[TB] FAIL merge%0d_beat got=%0d/%0d/%h exp=%0d/%0d/%h", t,
                                     obs[k].idx, obs[k].beat, obs[k].data, e.idx, e.beat, e.data);
                        end
                    end
                end
            end
            checks++;
            if (nAcc !== BEAT_NUM) begin failures++; $display("[TB] FAIL merge%0d_beat_count got=%0d exp=%0d", t, nAcc, BEAT_NUM); end
            checks++;
            if (doneCyc !== BEAT_NUM + 2) begin failures++; $display("[TB] FAIL merge%0d_done_cycle got=%0d exp=%0d", t, doneCyc, BEAT_NUM + 2); end
            checks++;
            if (bus.wb_busy !== 1'b0) begin failures++; $display("[TB] FAIL merge%0d_idle_after got=%0b exp=0", t, bus.wb_busy); end
            sb.delete();
        end
    endtask

    // FINISHED without a write: wb_enable low, then vl of zero
    task automatic test_no_write();
        int doneCyc;
        for (int t = 0; t < 2; t++) begin
            applyStimulus({8{32'hDEAD_BEEF}}, '0, '0, 1'b0, (t == 1), 1'b1, FOUR_BYTE,
                          (t == 1) ? 0 : 8, 5'd9, 1'b0);
            collectBeats(-1, 0, 0, 0, 0, doneCyc);
            checks++;
            if (obs.size() !== 0) begin failures++; $display("[TB] FAIL nowrite%0d_wr_en got=%0d beats exp=0", t, obs.size()); end
            checks++;
            if (doneCyc !== 1) begin failures++; $display("[TB] FAIL nowrite%0d_done_cycle got=%0d exp=1", t, doneCyc); end
            checks++;
            if (bus.wb_busy !== 1'b0) begin failures++; $display("[TB] FAIL nowrite%0d_idle_after got=%0b exp=0", t, bus.wb_busy); end
        end
    endtask

    // Ready low for 3 cycles on beat 1
    task automatic test_ready_stall();
        int doneCyc;
        int nBeat1;
        int nAcc;
        logic [BW-1:0] held;
        exp_t e;
        applyStimulus({4{64'h0F0F_0000_1234_ABCD}}, {8{32'h7777_7777}}, VLEN'(8'h6B), 1'b0, 1'b1,
                      1'b0, FOUR_BYTE, 7, 5'd17, 1'b1);
        collectBeats(1, 3, 0, 0, 0, doneCyc);
        nBeat1 = 0;
        nAcc   = 0;
        held   = '0;
        foreach (obs[k]) begin
            if (obs[k].beat == 1'b1) begin
                if (nBeat1 == 0) held = obs[k].data;
                nBeat1++;
                checks++;
                if (obs[k].data !== held) begin failures++; $display("[TB] FAIL stall_hold got=%h exp=%h", obs[k].data, held); end
            end
            if (obs[k].acc) begin
                nAcc++;
                checks++;
                if (sb.size() == 0) begin
                    failures++; $display("[TB] FAIL stall_extra_beat got=%h exp=none", obs[k].data);
                end else begin
                    e = sb.pop_front();
                    if (obs[k].data !== e.data || obs[k].idx !== e.idx || obs[k].beat !== e.beat) begin
                        failures++;
                        $display("[TB] FAIL stall_beat got=%0d/%0d/%h exp=%0d/%0d/%h",
                                 obs[k].idx, obs[k].beat, obs[k].data, e.idx, e.beat, e.data);
                    end
                end
            end
        end
        checks++;
        if (nBeat1 !== 4) begin failures++; $display("[TB] FAIL stall_beat1_cycles got=%0d exp=4", nBeat1); end
        checks++;
        if (nAcc !== BEAT_NUM) begin failures++; $display("[TB] FAIL stall_beat_count got=%0d exp=%0d", nAcc, BEAT_NUM); end
        checks++;
        if (doneCyc !== BEAT_NUM + 5) begin failures++; $display("[TB] FAIL stall_done_cycle got=%0d exp=%0d", doneCyc, BEAT_NUM + 5); end
        sb.delete();
    endtask

    // rdy_in low for 2 cycles during WRITE freezes the unit
    task automatic test_rdy_freeze();
        int doneCyc;
        int nAcc;
        exp_t e;
        applyStimulus({8{32'h2468_ACE0}}, {8{32'h1357_9BDF}}, '0, 1'b0, 1'b1, 1'b1, TWO_BYTE,
                      16, 5'd30, 1'b1);
        collectBeats(-1, 0, 0, 2, 2, doneCyc);
        nAcc = 0;
        foreach (obs[k]) begin
            if (obs[k].acc) begin
                nAcc++;
                checks++;
                if (sb.size() == 0) begin
                    failures++; $display("[TB] FAIL freeze_extra_beat got=%h exp=none", obs[k].data);
                end else begin
                    e = sb.pop_front();
                    if (obs[k].data !== e.data || obs[k].idx !== e.idx || obs[k].beat !== e.beat) begin
                        failures++;
                        $display("[TB] FAIL freeze_beat got=%0d/%0d/%h exp=%0d/%0d/%h",
                                 obs[k].idx, obs[k].beat, obs[k].data, e.idx, e.beat, e.data);
                    end
                end
            end
        end
        checks++;
        if (nAcc !== BEAT_NUM) begin failures++; $display("[TB] FAIL freeze_beat_count got=%0d exp=%0d", nAcc, BEAT_NUM); end
        checks++;
        if (doneCyc !== BEAT_NUM + 4) begin failures++; $display("[TB] FAIL freeze_done_cycle got=%0d exp=%0d", doneCyc, BEAT_NUM + 4); end
        sb.delete();
    endtask

    // Stray FINISHED during WRITE, then reset in the middle of a write
    task automatic test_overrun_reset();
        int doneCyc;
        int nAcc;
        exp_t e;
        checks++;
        if (bus.wb_overrun !== 1'b0) begin failures++; $display("[TB] FAIL overrun_pre got=%0b exp=0", bus.wb_overrun); end
        applyStimulus({8{32'hCAFE_F00D}}, {8{32'h0BAD_0BAD}}, VLEN'(8'h0F), 1'b0, 1'b1, 1'b0,
                      FOUR_BYTE, 6, 5'd12, 1'b1);
        collectBeats(-1, 0, 2, 0, 0, doneCyc);
        nAcc = 0;
        foreach (obs[k]) begin
            if (obs[k].acc) begin
                nAcc++;
                checks++;
                if (sb.size() == 0) begin
                    failures++; $display("[TB] FAIL overrun_extra_beat got=%h exp=none", obs[k].data);
                end else begin
                    e = sb.pop_front();
                    if (obs[k].data !== e.data || obs[k].idx !== e.idx || obs[k].beat !== e.beat) begin
                        failures++;
                        $display("[TB] FAIL overrun_beat got=%0d/%0d/%h exp=%0d/%0d/%h",
                                 obs[k].idx, obs[k].beat, obs[k].data, e.idx, e.beat, e.data);
                    end
                end
            end
        end
        checks++;
        if (nAcc !== BEAT_NUM) begin failures++; $display("[TB] FAIL overrun_beat_count got=%0d exp=%0d", nAcc, BEAT_NUM); end
        checks++;
        if (doneCyc !== BEAT_NUM + 2) begin failures++; $display("[TB] FAIL overrun_done_cycle got=%0d exp=%0d", doneCyc, BEAT_NUM + 2); end
        checks++;
        if (bus.wb_overrun !== 1'b1) begin failures++; $display("[TB] FAIL overrun_sticky got=%0b exp=1", bus.wb_overrun); end
        sb.delete();

        applyStimulus({8{32'h3C3C_3C3C}}, '0, '0, 1'b0, 1'b1, 1'b1, FOUR_BYTE, 8, 5'd21, 1'b0);
        bus.vreg_wr_ready = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.vreg_wr_en !== 1'b1) begin failures++; $display("[TB] FAIL midwrite_wr_en got=%0b exp=1", bus.vreg_wr_en); end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.wb_busy !== 1'b0 || bus.vreg_wr_en !== 1'b0 || bus.wb_done !== 1'b0) begin
            failures++; $display("[TB] FAIL midreset_ctrl got=%0b%0b%0b exp=000", bus.wb_busy, bus.vreg_wr_en, bus.wb_done);
        end
        checks++;
        if (bus.wb_overrun !== 1'b0) begin failures++; $display("[TB] FAIL midreset_overrun got=%0b exp=0", bus.wb_overrun); end
        checks++;
        if (bus.vreg_wr_data !== '0 || bus.vreg_wr_index !== '0 || bus.vreg_wr_beat !== '0) begin
            failures++; $display("[TB] FAIL midreset_wr_bus got=%h/%0d/%0d exp=0", bus.vreg_wr_data, bus.vreg_wr_index, bus.vreg_wr_beat);
        end
        rst = 1'b0;
        bus.vreg_wr_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_merge_patterns();
        test_no_write();
        test_ready_stall();
        test_rdy_freeze();
        test_overrun_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
